// File: rtl/adc_seg_display.sv
// XADC sample to millivolt BCD converter (multiply, then double-dabble) driving
// a multiplexed 7-segment display that shows the value as volts, D.DDD.
module adc_seg_display #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic [15:0] sample_in,
  input  logic        sample_valid,
  output logic        busy,
  output logic [15:0] mv_bcd,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, MULT, SHIFT, DONE} state_t;

  state_t      state_q, state_d;
  logic        busy_q, busy_d;
  logic [11:0] code_q, code_d;
  logic [21:0] dd_q, dd_d;
  logic [3:0]  iter_q, iter_d;
  logic [15:0] mv_bcd_q, mv_bcd_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;

  logic [21:0] prod;
  logic [11:0] bcd_adj;
  logic [3:0]  digit;
  logic        unused_bits;

  assign prod        = 22'(code_q) * 22'd1000;
  assign unused_bits = ^{sample_in[3:0], prod[11:0]};

  // dd_q holds {bcd[11:0], binary[9:0]}; correct each BCD nibble before the shift
  for (genvar gi = 0; gi < 3; gi++) begin : g_dabble
    assign bcd_adj[4*gi +: 4] = (dd_q[10+4*gi +: 4] >= 4'd5) ?
                                dd_q[10+4*gi +: 4] + 4'd3 : dd_q[10+4*gi +: 4];
  end

  // FSM: state register
  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sample_valid) state_d = MULT;
      MULT:    state_d = SHIFT;
      SHIFT:   if (iter_q == 4'd9) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy_d = (state_d != IDLE);
  end

  always_comb begin
    code_d   = code_q;
    dd_d     = dd_q;
    iter_d   = iter_q;
    mv_bcd_d = mv_bcd_q;
    case (state_q)
      IDLE: if (sample_valid) code_d = sample_in[15:4];
      MULT: begin
        dd_d   = {12'h000, prod[21:12]};
        iter_d = 4'd0;
      end
      SHIFT: begin
        dd_d   = {bcd_adj[10:0], dd_q[9:0], 1'b0};
        iter_d = iter_q + 4'd1;
      end
      DONE:    mv_bcd_d = {4'h0, dd_q[21:10]};
      default: ;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      code_q   <= '0;
      dd_q     <= '0;
      iter_q   <= '0;
      mv_bcd_q <= '0;
    end else begin
      code_q   <= code_d;
      dd_q     <= dd_d;
      iter_q   <= iter_d;
      mv_bcd_q <= mv_bcd_d;
    end
  end

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'd0:    seg_decode = 7'h40;
      4'd1:    seg_decode = 7'h79;
      4'd2:    seg_decode = 7'h24;
      4'd3:    seg_decode = 7'h30;
      4'd4:    seg_decode = 7'h19;
      4'd5:    seg_decode = 7'h12;
      4'd6:    seg_decode = 7'h02;
      4'd7:    seg_decode = 7'h78;
      4'd8:    seg_decode = 7'h00;
      4'd9:    seg_decode = 7'h10;
      default: seg_decode = 7'h7F;
    endcase
  endfunction

  always_comb begin
    case (idx_q)
      2'd0:    digit = mv_bcd_q[3:0];
      2'd1:    digit = mv_bcd_q[7:4];
      2'd2:    digit = mv_bcd_q[11:8];
      default: digit = mv_bcd_q[15:12];
    endcase
  end

  // Scan runs independently of conversions; outputs lag idx/mv_bcd by one cycle
  always_comb begin
    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      idx_d   = idx_q + 2'd1;
    end
    an_d  = ~(8'h01 << idx_q);
    seg_d = seg_decode(digit);
    dp_d  = (idx_q != 2'd3);
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      presc_q <= '0;
      idx_q   <= '0;
      an_q    <= 8'hFE;
      seg_q   <= 7'h40;
      dp_q    <= 1'b1;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign busy   = busy_q;
  assign mv_bcd = mv_bcd_q;
  assign an     = an_q;
  assign seg    = seg_q;
  assign dp     = dp_q;

endmodule

// File: tb/tb_adc_seg_display.sv
// Randomized bench for adc_seg_display: a cycle-level reference model (latency
// countdown plus arithmetic BCD and scan position) is checked every clock.
module tb_adc_seg_display;

  localparam int SCAN = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        busy;
  logic [15:0] mv_bcd;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int total = 0;
  int bad = 0;

  int          m_left = 0;
  int          m_n = 0;
  logic [15:0] m_mv = 16'h0000;
  logic [15:0] m_pend = 16'h0000;

  adc_seg_display #(.SCAN_DIV(SCAN)) dut (
    .CLK100MHZ(clk),
    .CPU_RESETN(rst_n),
    .sample_in(sample_in),
    .sample_valid(sample_valid),
    .busy(busy),
    .mv_bcd(mv_bcd),
    .an(an),
    .seg(seg),
    .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [15:0] to_bcd(input logic [11:0] code);
    int mv;
    logic [15:0] r;
    mv = (int'(code) * 1000) / 4096;
    r = 16'h0000;
    r[11:8] = 4'((mv / 100) % 10);
    r[7:4]  = 4'((mv / 10) % 10);
    r[3:0]  = 4'(mv % 10);
    return r;
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
      4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
      4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
      4'd9: return 7'h10;  default: return 7'h7F;
    endcase
  endfunction

  // One clock: advance the model with the inputs seen at the edge, then compare
  task automatic tick();
    logic [7:0] an_e;
    logic [6:0] seg_e;
    logic       dp_e;
    int         di;
    @(posedge clk);
    if (!rst_n) begin
      m_left = 0;
      m_mv   = 16'h0000;
      m_n    = 0;
      an_e   = 8'hFE;
      seg_e  = 7'h40;
      dp_e   = 1'b1;
    end else begin
      di    = (m_n / SCAN) % 4;
      an_e  = ~(8'h01 << di);
      seg_e = seg_of(m_mv[4*di +: 4]);
      dp_e  = (di != 3);
      m_n++;
      if (m_left == 0) begin
        if (sample_valid) begin
          m_left = 12;
          m_pend = to_bcd(sample_in[15:4]);
        end
      end else begin
        m_left--;
        if (m_left == 0) m_mv = m_pend;
      end
    end
    #1;
    check("an", 32'(an), 32'(an_e));
    check("seg", 32'(seg), 32'(seg_e));
    check("dp", 32'(dp), 32'(dp_e));
    check("busy", 32'(busy), 32'(m_left != 0));
    check("mv_bcd", 32'(mv_bcd), 32'(m_mv));
  endtask

  task automatic run_conv(input logic [15:0] s, input logic [15:0] want, input string tag);
    int nb;
    nb = 0;
    sample_in = s;
    sample_valid = 1'b1;
    tick();
    if (busy) nb++;
    sample_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (busy) nb++;
    end
    check({tag, "_busy_len"}, 32'(nb), 32'd12);
    check({tag, "_mv"}, 32'(mv_bcd), 32'(want));
    $display("conv %s sample=%h mv_bcd=%h busy_cycles=%0d", tag, s, mv_bcd, nb);
  endtask

  initial begin
    int nb;
    rst_n = 1'b0;
    sample_in = 16'hFFF0;
    sample_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("rst_an", 32'(an), 32'h0FE);
    check("rst_seg", 32'(seg), 32'h40);
    check("rst_mv", 32'(mv_bcd), 32'h0);
    sample_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    check("rst_ignored_valid", 32'(busy), 32'd0);

    run_conv(16'hFFF0, 16'h0999, "full");
    run_conv(16'h8000, 16'h0500, "half");
    run_conv(16'h0010, 16'h0000, "lsb");
    run_conv(16'h19A0, 16'h0100, "c410");

    // Scan with 0.999 on display: two full rotations
    for (int i = 0; i < 32; i++) tick();

    // A strobe while busy must be dropped
    nb = 0;
    sample_in = 16'h8000;
    sample_valid = 1'b1;
    tick();
    if (busy) nb++;
    sample_valid = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      if (i == 5) begin
        sample_in = 16'hFFF0;
        sample_valid = 1'b1;
      end
      tick();
      sample_valid = 1'b0;
      if (busy) nb++;
    end
    check("overlap_busy_len", 32'(nb), 32'd12);
    check("overlap_mv", 32'(mv_bcd), 32'h0500);
    tick();
    check("overlap_idle", 32'(busy), 32'd0);
    $display("overlap mv_bcd=%h busy_cycles=%0d", mv_bcd, nb);

    // Reset landing on the fifth SHIFT edge aborts the conversion
    sample_in = 16'hFFF0;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    tick();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_mv", 32'(mv_bcd), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check("abort_no_write", 32'(mv_bcd), 32'h0);
    $display("abort mv_bcd=%h busy=%0d", mv_bcd, busy);

    // Random strobes, including while busy, with rare resets
    for (int i = 0; i < 800; i++) begin
      sample_valid = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 7))
        0:       sample_in = 16'hFFF0;
        1:       sample_in = 16'h000F;
        default: sample_in = 16'($urandom);
      endcase
      rst_n = ($urandom_range(0, 199) != 0);
      tick();
      if (m_left == 0 && rst_n)
        $display("rand cycle=%0d mv_bcd=%h", i, mv_bcd);
    end
    rst_n = 1'b1;
    sample_valid = 1'b0;
    for (int i = 0; i < 16; i++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adc_seg_display.md
ADC_SEG_DISPLAY -- requirements
Module: adc_seg_display

Interface
REQ-001 Parameter SCAN_DIV, default 100000, clock cycles each digit is shown (legal range >= 2).
REQ-002 CLK100MHZ  input  1  sole clock; all logic on rising edge.
REQ-003 CPU_RESETN  input  1  reset, synchronous, active-low.
REQ-004 sample_in  input  16  XADC DO word; 12-bit unsigned code in [15:4], [3:0] ignored.
REQ-005 sample_valid  input  1  one-cycle strobe marking sample_in valid.
REQ-006 busy  output  1  high while a conversion is in progress; new samples ignored.
REQ-007 mv_bcd  output  16  displayed value, 4 BCD digits (thousands, hundreds, tens, ones of millivolts).
REQ-008 an  output  8  digit enables, active-low; an[i] selects digit i.
REQ-009 seg  output  7  segments, active-low, seg[0]=a ... seg[6]=g.
REQ-010 dp  output  1  decimal point, active-low.

Function
REQ-011 The FSM SHALL have states IDLE, MULT, SHIFT, DONE; busy = (state != IDLE), registered.
REQ-012 In IDLE, sample_valid=1 at edge k SHALL latch code = sample_in[15:4] and go to MULT; sample_valid in any other state SHALL be ignored, not queued.
REQ-013 MULT (edge k+1) SHALL compute mv = (code * 1000) >> 12, 22-bit product truncated, result 0..999 in 10 bits, then enter SHIFT with iteration counter 0.
REQ-014 SHIFT SHALL perform one double-dabble iteration per cycle (add 3 to each BCD nibble >= 5, then shift left one bit), exactly 10 iterations at edges k+2..k+11, then go to DONE.
REQ-015 DONE (edge k+12) SHALL write the BCD result to mv_bcd and return to IDLE; busy is high for exactly 12 cycles; the earliest next accepted strobe is at edge k+13.
REQ-016 mv_bcd[15:12] SHALL always be 0; mv_bcd SHALL change only in DONE or reset.
REQ-017 The display SHALL show volts as D3.D2D1D0: digit 3 = mv_bcd[15:12] with dp lit, digits 2..0 = mv_bcd[11:0]; leading zeros shown, not blanked.
REQ-018 A prescaler SHALL count 0..SCAN_DIV-1 and wrap; on wrap the 2-bit digit index SHALL advance 0->1->2->3->0.
REQ-019 an SHALL be 8'hFF with bit idx cleared; an[7:4] SHALL always be 1.
REQ-020 seg decode (hex, {g..a}): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10; nibbles 10-15 SHALL give 7F (all off).
REQ-021 dp SHALL be 0 only when idx=3, else 1.
REQ-022 an, seg, dp SHALL be registered and reflect idx and mv_bcd of the previous cycle (1-cycle lag).
REQ-023 A conversion completing while the display scans SHALL take effect at the next cycle without disturbing the scan sequence.

Reset
REQ-024 CPU_RESETN=0 at an edge SHALL set state=IDLE, busy=0, mv_bcd=16'h0000, prescaler=0, idx=0, an=8'hFE, seg=7'h40, dp=1.
REQ-025 Reset mid-conversion SHALL abort it; no partial or prior result is written to mv_bcd.
REQ-026 sample_valid during reset SHALL be ignored.

Verification
REQ-027 CPU_RESETN low 3 cycles -> an=8'hFE, seg=7'h40, dp=1, busy=0, mv_bcd=16'h0000.
REQ-028 sample_in=16'hFFF0 strobed at edge k -> busy=1 after edges k..k+11, busy=0 and mv_bcd=16'h0999 after edge k+12.
REQ-029 sample_in=16'h8000 -> 16'h0500; 16'h0010 -> 16'h0000; 16'h19A0 (code 410) -> 16'h0100.
REQ-030 Strobe 16'h8000, then strobe 16'hFFF0 at edge k+5 -> mv_bcd=16'h0500, second strobe ignored, busy pulse still 12 cycles.
REQ-031 SCAN_DIV=4, mv_bcd=16'h0999 -> an cycles FE,FD,FB,F7 for 4 cycles each; seg=7'h10 for an=FE/FD/FB with dp=1; seg=7'h40 with dp=0 for an=F7.
REQ-032 Reset at the 5th SHIFT cycle after a prior result of 16'h0500 -> busy=0, mv_bcd=16'h0000 after that edge; no later write.
